div_unit: RTL
=============

# div_unit

Iterative radix-2 integer divider for the RV64M DIV/DIVU/REM/REMU group. It answers the same `start`/`ready` request protocol the execution-complex stage uses to drive its multi-cycle multiply unit. The requester holds `start` high with stable operands until it sees `ready`. The divider captures the operands, iterates one quotient bit per cycle, and returns quotient and remainder together with a one-cycle `ready` pulse.

## Interface
- `XLEN`, 64: operand and result width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request. Level, held by the requester until `ready`.
- `abort`  in  1: pipeline flush. Kills any operation in progress.
- `signed_op`  in  1: 1 selects DIV/REM semantics, 0 selects DIVU/REMU.
- `a`  in  XLEN: dividend. Sampled only on capture.
- `b`  in  XLEN: divisor. Sampled only on capture.
- `quotient`  out  XLEN: registered quotient.
- `remainder`  out  XLEN: registered remainder.
- `ready`  out  1: result valid. One-cycle pulse.
- `busy`  out  1: high in BUSY and DONE, low in IDLE.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**, with `start` and not `abort` (capture):
  - latch |a| and |b| when `signed_op`, otherwise the raw values;
  - latch quotient sign = a[XLEN-1]^b[XLEN-1] and remainder sign = a[XLEN-1] (signed operations only);
  - clear the partial remainder and the iteration counter;
  - go to BUSY, or take the special-case path below.
- **Special cases** are decided at capture, skip BUSY, and go straight to DONE:
  - `b`==0: quotient = all ones, remainder = `a`;
  - `signed_op`, `a`==1<<(XLEN-1) and `b`==all ones: quotient = `a`, remainder = 0.
- **BUSY**, one step per cycle (restoring division):
  - form trial = {partial remainder, next dividend MSB} - divisor;
  - if the trial is non-negative, keep it and shift in quotient bit 1;
  - otherwise shift in quotient bit 0 and keep the untrial value;
  - the counter runs 0..XLEN-1 and needs a width of $clog2(XLEN)+1.
- **Last step** (counter == XLEN-1):
  - apply sign fix-up: negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set;
  - register both into `quotient` and `remainder`;
  - go to DONE.
- **DONE**: `ready`=1, then go to IDLE unconditionally. DONE never captures a new request.
- **`abort`** in any state: go to IDLE at the next edge. Abort has priority over `start` and over the transition to DONE. The `ready` pulse is suppressed. Output registers keep their previous values.
- `start` in BUSY or DONE is ignored. Operands are not re-sampled.
- `quotient` and `remainder` hold their value until the next completed operation.
- **Reset values**: state IDLE, `quotient`=0, `remainder`=0, `ready`=0, `busy`=0, all internal registers 0.
- **Reset mid-operation**: all outputs go to 0 immediately (asynchronous). There is no pulse after reset is released.

## Timing
- Cycle 0 is the first cycle in which `start` is high in IDLE. Capture happens at the end of cycle 0.
- Normal path: iterations run in cycles 1..XLEN and `ready` is high in cycle XLEN+1 (cycle 65 for XLEN=64).
- Special-case path: `ready` is high in cycle 1.
- The requester advances on the edge that ends the `ready` cycle.
- The divider is back in IDLE in the following cycle. A `start` still high there is treated as a new request, which gives a one-cycle bubble between operations.
- `busy` rises in cycle 1 and falls in the cycle after `ready`.
- `ready`, `quotient` and `remainder` are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `malu_pkg` holds:
  - `div_state_t` (DIV_IDLE, DIV_BUSY, DIV_DONE);
  - constant `DIV_MIN_SIGNED`;
  - helper function `twos_neg` for the sign fix-up.
- No sub-module is needed. The datapath (one XLEN+1-bit subtractor plus shift registers) and the FSM sit in one module.

## Test plan
- **Signed divide**: a=100, b=-7, `signed_op`=1 -> `ready` in cycle 65, `quotient`=0xFFFFFFFFFFFFFFF2 (-14), `remainder`=2.
- **Unsigned divide**: a=0xFFFFFFFFFFFFFFFF, b=2, `signed_op`=0 -> `quotient`=0x7FFFFFFFFFFFFFFF, `remainder`=1, cycle 65.
- **Divide by zero**: a=-5, b=0, `signed_op`=1 -> `ready` in cycle 1, `quotient`=all ones, `remainder`=0xFFFFFFFFFFFFFFFB.
- **Signed overflow**: a=0x8000000000000000, b=-1, `signed_op`=1 -> `ready` in cycle 1, `quotient`=0x8000000000000000, `remainder`=0.
- **Abort, then new request**:
  - `abort` in cycle 20 -> no `ready`, `busy`=0 in cycle 21, outputs unchanged;
  - then a=7, b=2 unsigned -> `quotient`=3, `remainder`=1.
- **Back-to-back and reset**:
  - `start` held high for two operations (20/3, then 9/4) -> `ready` in cycles 65 and 131, results 6/2 then 2/1;
  - `reset` low in cycle 30 of a third operation -> all outputs 0 at once, no `ready` after release.

Source files
------------

// File: rtl/malu_pkg.sv
// -----------------------------------------------------------------------------
// malu_pkg
// Shared definitions for the multi-cycle arithmetic units.
//   XLEN           : operand / result width
//   div_state_t    : divider FSM states
//   DIV_MIN_SIGNED : most negative signed XLEN-bit value
//   twos_neg()     : two's complement negation used for sign fix-up
// -----------------------------------------------------------------------------
package malu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam logic [XLEN-1:0] DIV_MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow are resolved
// at capture and skip the iteration phase.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : request level, held until ready
//   abort      : flush, kills any operation in progress
//   signed_op  : 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   a, b       : dividend / divisor, sampled only on capture
//   quotient   : registered quotient
//   remainder  : registered remainder
//   ready      : one-cycle result-valid pulse
//   busy       : high while an operation is in BUSY or DONE
// -----------------------------------------------------------------------------
module div_unit
    import malu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            signed_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            ready,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    div_state_t       state_reg;
    logic [XLEN-1:0]  dvd_reg;        // dividend bits shift out of MSB, quotient bits shift into LSB
    logic [XLEN-1:0]  dvs_reg;        // divisor magnitude
    logic [XLEN-1:0]  rem_reg;        // partial remainder
    logic [CNT_W-1:0] cnt_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [XLEN-1:0]  quotient_reg;
    logic [XLEN-1:0]  remainder_reg;
    logic             ready_reg;
    logic             busy_reg;

    // Capture-side operand conditioning
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            is_div0, is_ovf;

    assign a_neg   = signed_op & a[XLEN-1];
    assign b_neg   = signed_op & b[XLEN-1];
    assign a_abs   = a_neg ? twos_neg(a) : a;
    assign b_abs   = b_neg ? twos_neg(b) : b;
    assign is_div0 = (b == '0);
    assign is_ovf  = signed_op && (a == DIV_MIN_SIGNED) && (b == '1);

    // One restoring step. The partial remainder is always below the divisor,
    // so the true trial result lies in (-2^XLEN, 2^XLEN) and an XLEN+1-bit
    // subtraction yields a correct sign bit.
    logic [XLEN:0]   partial, trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_step, quo_step, quo_fixed, rem_fixed;

    assign partial   = {rem_reg, dvd_reg[XLEN-1]};
    assign trial     = partial - {1'b0, dvs_reg};
    assign trial_ok  = ~trial[XLEN];
    assign rem_step  = trial_ok ? trial[XLEN-1:0] : partial[XLEN-1:0];
    assign quo_step  = {dvd_reg[XLEN-2:0], trial_ok};
    assign quo_fixed = q_neg_reg ? twos_neg(quo_step) : quo_step;
    assign rem_fixed = r_neg_reg ? twos_neg(rem_step) : rem_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= DIV_IDLE;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            cnt_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                DIV_IDLE: begin
                    if (start && !abort) begin
                        dvd_reg   <= a_abs;
                        dvs_reg   <= b_abs;
                        q_neg_reg <= a_neg ^ b_neg;
                        r_neg_reg <= a_neg;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        if (is_div0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= a;
                            ready_reg     <= 1'b1;
                            state_reg     <= DIV_DONE;
                        end else if (is_ovf) begin
                            quotient_reg  <= a;
                            remainder_reg <= '0;
                            ready_reg     <= 1'b1;
                            state_reg     <= DIV_DONE;
                        end else begin
                            state_reg <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (abort) begin
                        state_reg <= DIV_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        dvd_reg <= quo_step;
                        rem_reg <= rem_step;
                        if (cnt_reg == LAST_STEP) begin
                            quotient_reg  <= quo_fixed;
                            remainder_reg <= rem_fixed;
                            ready_reg     <= 1'b1;
                            state_reg     <= DIV_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end
                DIV_DONE: begin
                    // Never captures; always returns to IDLE, giving the bubble.
                    state_reg <= DIV_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign ready     = ready_reg;
    assign busy      = busy_reg;

endmodule
